// File: rtl/pe_window_sequencer.sv
// pe_window_sequencer
//   Write/read pointer sequencer for the circular input buffer (depth
//   D = 2**BufferWidth) in front of one PE group. Incoming samples are
//   written at wr_ptr; reads walk a KernelSize-tap window starting at base,
//   and the window slides by Stride after each completed output. done pulses
//   once after num_out windows have been read.
//
//   Optional feature macro: PE_STALL_CNT_EN adds stall_cycles[15:0], a
//   saturating count of RUN cycles where the PE was ready but no tap was
//   available (input starvation).
//
// Ports:
//   clk, aclr_n          clock (rising edge), asynchronous active-low reset
//   clk_en, sclr         clock enable (freezes all state), synchronous clear
//   start, num_out       job launch (IDLE only) and number of outputs
//   in_valid / in_ready  input sample handshake
//   wr_en, wr_ptr        buffer write strobe and address
//   pe_ready             PE group can take a tap this cycle
//   rd_en, rd_ptr        buffer read strobe and address
//   tap_idx, last_tap    tap index of the current read, final-tap flag
//   busy, done           FILL/RUN indicator, one-cycle job-end pulse
//   stall_cycles         (PE_STALL_CNT_EN only) starvation counter
module pe_window_sequencer #(
    parameter int unsigned BufferWidth   = 2,
    parameter int unsigned KernelSize    = 3,
    parameter int unsigned Stride        = 1,
    parameter int unsigned OutCountWidth = 8
) (
    input  logic                     clk,
    input  logic                     aclr_n,
    input  logic                     clk_en,
    input  logic                     sclr,
    input  logic                     start,
    input  logic [OutCountWidth-1:0] num_out,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     wr_en,
    output logic [BufferWidth-1:0]   wr_ptr,
    input  logic                     pe_ready,
    output logic                     rd_en,
    output logic [BufferWidth-1:0]   rd_ptr,
    output logic [BufferWidth:0]     tap_idx,
    output logic                     last_tap,
    output logic                     busy,
`ifdef PE_STALL_CNT_EN
    output logic                     done,
    output logic [15:0]              stall_cycles
`else
    output logic                     done
`endif
);

    localparam int unsigned Depth = 1 << BufferWidth;
    localparam int unsigned CntW  = BufferWidth + 1;
    localparam int unsigned TotW  = OutCountWidth + BufferWidth + 1;

    localparam logic [CntW-1:0] DepthC  = CntW'(Depth);
    localparam logic [CntW-1:0] KernC   = CntW'(KernelSize);
    localparam logic [CntW-1:0] KLastC  = CntW'(KernelSize - 1);
    localparam logic [CntW-1:0] StrideC = CntW'(Stride);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [BufferWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [BufferWidth-1:0]   base_q, base_d;
    logic [CntW-1:0]          tap_q, tap_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [TotW-1:0]          accepted_q, accepted_d;
    logic [TotW-1:0]          total_q, total_d;
    logic [OutCountWidth-1:0] out_cnt_q, out_cnt_d;
    logic [OutCountWidth-1:0] num_out_q, num_out_d;
`ifdef PE_STALL_CNT_EN
    logic [15:0]              stall_q, stall_d;
`endif

    // Datapath outputs are decoded from registered state only.
    always_comb begin
        busy     = (state_q == S_FILL) || (state_q == S_RUN);
        in_ready = busy && (cnt_q < DepthC) && (accepted_q < total_q);
        wr_en    = in_valid && in_ready && clk_en;
        // cnt_q > tap_q keeps every read behind the written data.
        rd_en    = (state_q == S_RUN) && pe_ready && (cnt_q > tap_q) && clk_en;
        last_tap = rd_en && (tap_q == KLastC);
        rd_ptr   = base_q + tap_q[BufferWidth-1:0];
        tap_idx  = tap_q;
        wr_ptr   = wr_ptr_q;
        done     = (state_q == S_DONE) && clk_en;
    end

`ifdef PE_STALL_CNT_EN
    assign stall_cycles = stall_q;
`endif

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        base_d     = base_q;
        tap_d      = tap_q;
        accepted_d = accepted_q;
        total_d    = total_q;
        out_cnt_d  = out_cnt_q;
        num_out_d  = num_out_q;
        cnt_d      = cnt_q + (wr_en ? CntW'(1) : '0);
`ifdef PE_STALL_CNT_EN
        stall_d    = stall_q;
`endif

        if (wr_en) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            accepted_d = accepted_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    // A new job restarts the buffer from slot 0.
                    num_out_d  = num_out;
                    total_d    = (TotW'(num_out) - TotW'(1)) * TotW'(Stride)
                               + TotW'(KernelSize);
                    wr_ptr_d   = '0;
                    base_d     = '0;
                    tap_d      = '0;
                    cnt_d      = '0;
                    accepted_d = '0;
                    out_cnt_d  = '0;
`ifdef PE_STALL_CNT_EN
                    stall_d    = '0;
`endif
                    state_d    = (num_out == '0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                // Looking at the next occupancy lets the first read happen
                // in the cycle right after the KernelSize-th write.
                if (cnt_d >= KernC) state_d = S_RUN;
            end
            S_RUN: begin
`ifdef PE_STALL_CNT_EN
                if (pe_ready && !rd_en && (stall_q != 16'hFFFF))
                    stall_d = stall_q + 16'd1;
`endif
                if (rd_en) begin
                    if (last_tap) begin
                        tap_d     = '0;
                        base_d    = base_q + BufferWidth'(Stride);
                        cnt_d     = cnt_d - StrideC;
                        out_cnt_d = out_cnt_q + 1'b1;
                        if (out_cnt_q == num_out_q - 1'b1) begin
                            state_d = S_DONE;
                            cnt_d   = '0;
                        end
                    end else begin
                        tap_d = tap_q + 1'b1;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            base_q     <= '0;
            tap_q      <= '0;
            cnt_q      <= '0;
            accepted_q <= '0;
            total_q    <= '0;
            out_cnt_q  <= '0;
            num_out_q  <= '0;
`ifdef PE_STALL_CNT_EN
            stall_q    <= '0;
`endif
        end else if (clk_en) begin
            if (sclr) begin
                state_q    <= S_IDLE;
                wr_ptr_q   <= '0;
                base_q     <= '0;
                tap_q      <= '0;
                cnt_q      <= '0;
                accepted_q <= '0;
                total_q    <= '0;
                out_cnt_q  <= '0;
                num_out_q  <= '0;
`ifdef PE_STALL_CNT_EN
                stall_q    <= '0;
`endif
            end else begin
                state_q    <= state_d;
                wr_ptr_q   <= wr_ptr_d;
                base_q     <= base_d;
                tap_q      <= tap_d;
                cnt_q      <= cnt_d;
                accepted_q <= accepted_d;
                total_q    <= total_d;
                out_cnt_q  <= out_cnt_d;
                num_out_q  <= num_out_d;
`ifdef PE_STALL_CNT_EN
                stall_q    <= stall_d;
`endif
            end
        end
    end

endmodule

// File: tb/tb_pe_window_sequencer.sv
// tb_pe_window_sequencer
//   Scoreboard bench for pe_window_sequencer with default parameters
//   (D=4, K=3, S=1). Each job pushes the expected write addresses and the
//   expected window reads (slot, tap, last flag, sample number) into queues;
//   a negedge monitor pops and compares on wr_en / rd_en / done, and also
//   checks that every read slot holds the sample the window needs.
module tb_pe_window_sequencer;

    localparam int D = 4;
    localparam int K = 3;
    localparam int S = 1;

    logic       clk = 1'b0;
    logic       aclr_n, clk_en, sclr, start, in_valid, pe_ready;
    logic [7:0] num_out;
    logic       in_ready, wr_en, rd_en, last_tap, busy, done;
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] tap_idx;
`ifdef PE_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    pe_window_sequencer #(
        .BufferWidth(2), .KernelSize(K), .Stride(S), .OutCountWidth(8)
    ) dut (
        .clk(clk), .aclr_n(aclr_n), .clk_en(clk_en), .sclr(sclr),
        .start(start), .num_out(num_out), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .wr_ptr(wr_ptr),
        .pe_ready(pe_ready), .rd_en(rd_en), .rd_ptr(rd_ptr),
        .tap_idx(tap_idx), .last_tap(last_tap), .busy(busy),
`ifdef PE_STALL_CNT_EN
        .done(done), .stall_cycles(stall_cycles)
`else
        .done(done)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int ptr; int tap; int last; int sample; } rd_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   sb_on = 1'b1;
    int   exp_wr_q[$];
    rd_t  exp_rd_q[$];
    int   mem[D];
    int   wr_seq, nwr_job, nrd_job, done_seen;
    int   kth_wr_cyc, first_rd_cyc, last_rd_cyc, done_cyc, start_cyc, cur_n;
    int   ew;
    rd_t  er;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every DUT event against the head of its queue.
    always @(negedge clk) begin
        if (sb_on && aclr_n) begin
            if (wr_en) begin
                if (exp_wr_q.size() == 0) check("wr_unexpected", exp_wr_q.size(), 1);
                else begin
                    ew = exp_wr_q.pop_front();
                    check("wr_ptr", int'(wr_ptr), ew);
                end
                mem[wr_ptr] = wr_seq;
                wr_seq++;
                nwr_job++;
                if (nwr_job == K) kth_wr_cyc = cyc;
            end
            if (rd_en) begin
                if (exp_rd_q.size() == 0) check("rd_unexpected", exp_rd_q.size(), 1);
                else begin
                    er = exp_rd_q.pop_front();
                    check("rd_ptr", int'(rd_ptr), er.ptr);
                    check("tap_idx", int'(tap_idx), er.tap);
                    check("last_tap", int'(last_tap), er.last);
                    check("rd_data", mem[rd_ptr], er.sample);
                end
                if (nrd_job == 0) first_rd_cyc = cyc;
                last_rd_cyc = cyc;
                nrd_job++;
            end
            if (done) begin
                done_seen++;
                done_cyc = cyc;
            end
        end
    end

    // Reference: a job of n outputs consumes samples 0..total-1 written to
    // slot i mod D; output o reads samples o*S .. o*S+K-1 in tap order.
    task automatic start_job(input int n);
        int total;
        rd_t r;
        exp_wr_q.delete();
        exp_rd_q.delete();
        foreach (mem[i]) mem[i] = -1;
        wr_seq = 0; nwr_job = 0; nrd_job = 0; done_seen = 0;
        kth_wr_cyc = -1; first_rd_cyc = -1; last_rd_cyc = -1; done_cyc = -1;
        cur_n = n;
        total = (n > 0) ? (n - 1) * S + K : 0;
        for (int i = 0; i < total; i++) exp_wr_q.push_back(i % D);
        for (int o = 0; o < n; o++)
            for (int t = 0; t < K; t++) begin
                r.sample = o * S + t;
                r.ptr    = r.sample % D;
                r.tap    = t;
                r.last   = (t == K - 1) ? 1 : 0;
                exp_rd_q.push_back(r);
            end
        start = 1'b1;
        num_out = 8'(n);
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        num_out = 8'($urandom_range(0, 255));
    endtask

    task automatic drive_cycle(input bit iv, input bit pr);
        in_valid = iv;
        pe_ready = pr;
        @(posedge clk); #1;
    endtask

    task automatic finish_job(input int piv, input int ppr);
        int k = 0;
        while (done_seen == 0 && k < 3000) begin
            drive_cycle($urandom_range(0, 99) < piv, $urandom_range(0, 99) < ppr);
            k++;
        end
        drive_cycle(1'b0, 1'b0);
        check("done_count", done_seen, 1);
        check("idle_busy", int'(busy), 0);
        check("wr_left", exp_wr_q.size(), 0);
        check("rd_left", exp_rd_q.size(), 0);
        if (cur_n > 0) check("done_after_last_tap", done_cyc, last_rd_cyc + 1);
        else           check("done_after_start", done_cyc, start_cyc + 1);
    endtask

    task automatic flush();
        exp_wr_q.delete();
        exp_rd_q.delete();
    endtask

    initial begin
        aclr_n = 1'b0; clk_en = 1'b1; sclr = 1'b0; start = 1'b0;
        num_out = '0; in_valid = 1'b0; pe_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_wr_ptr", int'(wr_ptr), 0);
        check("rst_rd_ptr", int'(rd_ptr), 0);
        check("rst_tap_idx", int'(tap_idx), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_done", int'(done), 0);
        aclr_n = 1'b1;
        @(posedge clk); #1;

        // Full throughput, num_out=2, then 4 (pointer wrap).
        start_job(2);
        finish_job(100, 100);
        check("first_rd_latency_n2", first_rd_cyc, kth_wr_cyc + 1);
        start_job(4);
        finish_job(100, 100);
        check("first_rd_latency_n4", first_rd_cyc, kth_wr_cyc + 1);

        // Zero-output job.
        start_job(0);
        finish_job(100, 100);

        // Full buffer: PE held off while input streams in.
        start_job(3);
        repeat (10) drive_cycle(1'b1, 1'b0);
        check("full_nwr", nwr_job, D);
        check("full_in_ready", int'(in_ready), 0);
        check("full_wr_ptr", int'(wr_ptr), 0);
        check("full_busy", int'(busy), 1);
        finish_job(100, 100);

        // sclr with clk_en=0 has no effect; the job then finishes normally.
        start_job(4);
        repeat (5) drive_cycle(1'b1, 1'b1);
        clk_en = 1'b0; sclr = 1'b1; in_valid = 1'b1; pe_ready = 1'b1;
        #1;
        check("frz_wr_en", int'(wr_en), 0);
        check("frz_rd_en", int'(rd_en), 0);
        repeat (3) @(posedge clk);
        #1;
        check("frz_busy", int'(busy), 1);
        check("frz_wr_ptr", int'(wr_ptr), 0);
        check("frz_tap_idx", int'(tap_idx), 2);
        check("frz_rd_ptr", int'(rd_ptr), 2);
        clk_en = 1'b1; sclr = 1'b0;
        finish_job(100, 100);

        // sclr mid-RUN.
        start_job(5);
        repeat (6) drive_cycle(1'b1, 1'b1);
        check("pre_sclr_busy", int'(busy), 1);
        sb_on = 1'b0;
        sclr = 1'b1;
        @(posedge clk); #1;
        sclr = 1'b0;
        check("sclr_busy", int'(busy), 0);
        check("sclr_wr_ptr", int'(wr_ptr), 0);
        check("sclr_rd_ptr", int'(rd_ptr), 0);
        check("sclr_tap_idx", int'(tap_idx), 0);
        drive_cycle(1'b1, 1'b1);
        check("sclr_idle_in_ready", int'(in_ready), 0);
        flush();
        sb_on = 1'b1;

        // Asynchronous reset mid-RUN, away from any clock edge.
        start_job(4);
        repeat (5) drive_cycle(1'b1, 1'b1);
        check("pre_aclr_busy", int'(busy), 1);
        check("pre_aclr_rd_ptr", int'(rd_ptr), 2);
        sb_on = 1'b0;
        #2 aclr_n = 1'b0;
        #1;
        check("aclr_busy", int'(busy), 0);
        check("aclr_rd_en", int'(rd_en), 0);
        check("aclr_rd_ptr", int'(rd_ptr), 0);
        check("aclr_wr_ptr", int'(wr_ptr), 0);
        check("aclr_tap_idx", int'(tap_idx), 0);
        check("aclr_in_ready", int'(in_ready), 0);
        #1 aclr_n = 1'b1;
        @(posedge clk); #1;
        flush();
        sb_on = 1'b1;

        // Input gap mid-RUN: exactly two starved cycles with pe_ready high.
        start_job(3);
        repeat (3) drive_cycle(1'b1, 1'b1);
        repeat (6) drive_cycle(1'b0, 1'b1);
        finish_job(100, 100);
`ifdef PE_STALL_CNT_EN
        check("stall_cycles", int'(stall_cycles), 2);
`endif

        // Randomized jobs.
        for (int j = 0; j < 20; j++) begin
            start_job($urandom_range(0, 6));
            finish_job($urandom_range(30, 100), $urandom_range(30, 100));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
